alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU between two requesters. Each requester presents an operation (A, B, 4-bit Sel) through a valid/ready handshake. The arbiter grants one request and drives the ALU from registered operands. It captures Out/Carry and returns them to the granted requester through a valid/ready response channel. The block sits between the two datapath clients and the single ALU instance.

## Interface
Parameters:
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- req0_sel / req1_sel  in  4  ALU opcode (ALU encoding, 0000 add … 1111 equal).
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  requester consumes the result.
- rsp0_out / rsp1_out  out  8  captured ALU Out.
- rsp0_carry / rsp1_carry  out  1  captured ALU Carry.
- alu_a, alu_b  out  8  ALU operand drive.
- alu_sel  out  4  ALU opcode drive.
- alu_out  in  8  ALU result.
- alu_carry  in  1  ALU carry (carry of A+B, independent of Sel).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only for the winner among valid requesters.
  - If only one requester is valid, it wins.
  - If both are valid, the requester holding priority wins.
  - On an accepted handshake: latch a/b/sel into the operand registers, record the grant id, go to EXEC.
  - Priority passes to the other requester immediately after each grant.
- EXEC:
  - The operand registers drive alu_a/alu_b/alu_sel.
  - At the end of the cycle, alu_out/alu_carry are captured into the result registers.
  - Go to RESP.
- RESP:
  - rspN_valid=1 for the granted requester only.
  - rspN_out/rspN_carry hold stable until rspN_ready=1.
  - On the rsp handshake, go to IDLE. Both reqN_ready stay 0 throughout RESP.
- The ALU is driven from registers only: alu_a/alu_b/alu_sel hold their last value outside EXEC, so no glitching follows request inputs.
- Results pass through untouched: 8-bit wrap on add/sub/mul, and Carry is as the ALU reports it.
- The non-granted rsp channel keeps valid=0. Its out/carry read 0.

## Timing
- Reset values:
  - state=IDLE, priority=RR_INIT.
  - All reqN_ready=0 while rst is high.
  - All rspN_valid=0, rspN_out=8'h00, rspN_carry=0.
  - alu_a=alu_b=8'h00, alu_sel=4'b0000.
- Latency: request accepted at edge T; EXEC during cycle T+1; rsp_valid high from cycle T+2.
- Minimum of 3 cycles per operation when rsp_ready is held high. The next request is accepted in the cycle after the response handshake.
- A requester whose valid is held while the other is granted is served next (no starvation). Worst-case wait is one other operation.
- Requester inputs may change freely while not accepted. After acceptance they are ignored until the next grant.
- rsp_ready asserted before rsp_valid has no effect.
- Reset mid-operation (EXEC or RESP):
  - Abort to IDLE; the pending response is discarded and never delivered.
  - Priority returns to RR_INIT.

## Configuration
- Macro ALU_ARB_DIV0_EN.
- Defined: an accepted request with sel=4'b0011 and b=8'h00 returns out=8'hFF and carry=0 in the response. The captured alu_out/alu_carry are overridden. Timing is unchanged.
- Undefined: the ALU result is captured as-is for every opcode, including divide-by-zero.

## Test plan
- Single request: req0 a=8'hF0, b=8'h20, sel=0000.
  - Accepted at T; rsp0_valid at T+2 with out=8'h10, carry=1.
  - rsp1_valid stays 0.
- Contention: both valid from reset with RR_INIT=0, rsp_ready tied high.
  - Grants alternate 0,1,0,1; one grant every 3 cycles.
  - req1 sel=1111, a=b=8'h33 → rsp1_out=8'h01.
- Backpressure: hold rsp1_ready=0 for 5 cycles.
  - rsp1_valid and rsp1_out stay stable; both req_ready stay 0.
  - After rsp1_ready=1, the next request is accepted one cycle later.
- Divide by zero: req0 a=8'h40, b=0, sel=0011.
  - With ALU_ARB_DIV0_EN defined: out=8'hFF, carry=0.
  - With a=8'h40, b=8'h08, sel=0011: out=8'h08 in both builds.
- Reset in RESP: assert rst for 1 cycle while rsp0_valid=1.
  - Next cycle: rsp0_valid=0, outputs at reset values.
  - Priority=RR_INIT; no stale response appears afterward.
- Operand isolation: change req0_a after acceptance during EXEC.
  - Captured result reflects the latched operands; alu_a does not change until the next grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 8-bit ALU between two requesters.
// Optional feature: define ALU_ARB_DIV0_EN to force out=8'hFF, carry=0 on divide-by-zero.
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_sel,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_out,
  output logic       rsp0_carry,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_out,
  output logic       rsp1_carry,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic       grant_q, grant_d;
  logic [7:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [3:0] sel_q, sel_d;
  logic       carry_q, carry_d;

  logic       win0, win1;
  logic [7:0] resOut;
  logic       resCarry;

  // prio_q names the requester that wins when both are valid
  assign win0 = req0_valid & (~req1_valid | ~prio_q);
  assign win1 = req1_valid & (~req0_valid |  prio_q);

  assign req0_ready = (state_q == IDLE) & ~rst & win0;
  assign req1_ready = (state_q == IDLE) & ~rst & win1;

  assign rsp0_valid = (state_q == RESP) & ~grant_q;
  assign rsp1_valid = (state_q == RESP) &  grant_q;
  assign rsp0_out   = rsp0_valid ? out_q : 8'h00;
  assign rsp1_out   = rsp1_valid ? out_q : 8'h00;
  assign rsp0_carry = rsp0_valid & carry_q;
  assign rsp1_carry = rsp1_valid & carry_q;

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_sel = sel_q;

`ifdef ALU_ARB_DIV0_EN
  assign resOut   = (sel_q == 4'b0011 && b_q == 8'h00) ? 8'hFF : alu_out;
  assign resCarry = (sel_q == 4'b0011 && b_q == 8'h00) ? 1'b0  : alu_carry;
`else
  assign resOut   = alu_out;
  assign resCarry = alu_carry;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    out_d   = out_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (win0 | win1) begin
          grant_d = win1;
          a_d     = win1 ? req1_a   : req0_a;
          b_d     = win1 ? req1_b   : req0_b;
          sel_d   = win1 ? req1_sel : req0_sel;
          prio_d  = ~win1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_d   = resOut;
        carry_d = resCarry;
        state_d = RESP;
      end
      RESP: begin
        if (grant_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any in-flight operation and discards its response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      grant_q <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sel_q   <= 4'b0000;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp0_carry, rsp1_valid, rsp1_ready, rsp1_carry;
  logic [7:0] rsp0_out, rsp1_out;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_carry;
  logic [8:0] aluSum;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_out(rsp0_out), .rsp0_carry(rsp0_carry),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_out(rsp1_out), .rsp1_carry(rsp1_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  // Stand-in ALU: carry is always that of A+B; divide by zero yields 8'h00
  always_comb begin
    aluSum    = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = aluSum[8];
    case (alu_sel)
      4'b0000: alu_out = aluSum[7:0];
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a * alu_b;
      4'b0011: alu_out = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      4'b1111: alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic [7:0] a,
                               input logic [7:0] b, input logic [3:0] sel);
    if (port == 0) begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_sel = sel;
    end
  endtask

  initial begin
    logic [7:0] div0Out;
    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    applyStimulus(0, 1'b1, 8'h11, 8'h22, 4'b0000);
    applyStimulus(1, 1'b1, 8'h33, 8'h44, 4'b0000);
    tick();
    tick();

    // Reset state, with both requesters valid
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 0);
    checkOutput("rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("rst_rsp0_out", rsp0_out, 8'h00);
    checkOutput("rst_alu_a", alu_a, 8'h00);
    checkOutput("rst_alu_sel", alu_sel, 4'b0000);

    // Single request plus operand isolation
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'b0000);
    applyStimulus(0, 1'b1, 8'hF0, 8'h20, 4'b0000);
    rst = 1'b0;
    #1;
    checkOutput("single_req0_ready", req0_ready, 1);
    tick();
    applyStimulus(0, 1'b0, 8'h55, 8'h20, 4'b0000);
    checkOutput("exec_alu_a", alu_a, 8'hF0);
    checkOutput("exec_rsp0_valid", rsp0_valid, 0);
    checkOutput("exec_req0_ready", req0_ready, 0);
    tick();
    checkOutput("single_rsp0_valid", rsp0_valid, 1);
    checkOutput("single_rsp0_out", rsp0_out, 8'h10);
    checkOutput("single_rsp0_carry", rsp0_carry, 1);
    checkOutput("single_rsp1_valid", rsp1_valid, 0);
    checkOutput("single_rsp1_out", rsp1_out, 8'h00);
    checkOutput("resp_alu_a_hold", alu_a, 8'hF0);
    rsp0_ready = 1'b1;
    tick();
    checkOutput("single_done_rsp0_valid", rsp0_valid, 0);
    checkOutput("idle_alu_a_hold", alu_a, 8'hF0);

    // Contention from a fresh reset: grants alternate 0,1,0,1 every 3 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    applyStimulus(0, 1'b1, 8'h01, 8'h02, 4'b0000);
    applyStimulus(1, 1'b1, 8'h33, 8'h33, 4'b1111);
    #1;
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("cont%0d_req0_ready", g), req0_ready, (g % 2 == 0));
      checkOutput($sformatf("cont%0d_req1_ready", g), req1_ready, (g % 2 == 1));
      tick();
      tick();
      if (g % 2 == 0) begin
        checkOutput($sformatf("cont%0d_rsp0_valid", g), rsp0_valid, 1);
        checkOutput($sformatf("cont%0d_rsp0_out", g), rsp0_out, 8'h03);
        checkOutput($sformatf("cont%0d_rsp1_valid", g), rsp1_valid, 0);
      end else begin
        checkOutput($sformatf("cont%0d_rsp1_valid", g), rsp1_valid, 1);
        checkOutput($sformatf("cont%0d_rsp1_out", g), rsp1_out, 8'h01);
        checkOutput($sformatf("cont%0d_rsp1_carry", g), rsp1_carry, 0);
        checkOutput($sformatf("cont%0d_rsp0_valid", g), rsp0_valid, 0);
      end
      tick();
    end

    // Backpressure on rsp1 for 5 cycles; req0 waits meanwhile
    applyStimulus(0, 1'b0, 8'h40, 8'h08, 4'b0011);
    rsp1_ready = 1'b0;
    #1;
    checkOutput("bp_req1_ready", req1_ready, 1);
    tick();
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'b0000);
    applyStimulus(0, 1'b1, 8'h40, 8'h08, 4'b0011);
    tick();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp%0d_rsp1_valid", c), rsp1_valid, 1);
      checkOutput($sformatf("bp%0d_rsp1_out", c), rsp1_out, 8'h01);
      checkOutput($sformatf("bp%0d_req0_ready", c), req0_ready, 0);
      checkOutput($sformatf("bp%0d_req1_ready", c), req1_ready, 0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    checkOutput("bp_after_rsp1_valid", rsp1_valid, 0);
    checkOutput("bp_after_req0_ready", req0_ready, 1);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'b0000);
    tick();
    checkOutput("div_rsp0_valid", rsp0_valid, 1);
    checkOutput("div_rsp0_out", rsp0_out, 8'h08);
    checkOutput("div_rsp0_carry", rsp0_carry, 0);
    tick();

    // Divide by zero
`ifdef ALU_ARB_DIV0_EN
    div0Out = 8'hFF;
`else
    div0Out = 8'h00;
`endif
    applyStimulus(0, 1'b1, 8'h40, 8'h00, 4'b0011);
    #1;
    checkOutput("div0_req0_ready", req0_ready, 1);
    tick();
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'b0000);
    tick();
    checkOutput("div0_rsp0_out", rsp0_out, div0Out);
    checkOutput("div0_rsp0_carry", rsp0_carry, 0);
    tick();

    // Reset while a response is pending; priority returns to requester 0
    applyStimulus(1, 1'b1, 8'h05, 8'h06, 4'b0000);
    #1;
    checkOutput("pre_rst_req1_ready", req1_ready, 1);
    tick();
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'b0000);
    rsp1_ready = 1'b0;
    tick();
    checkOutput("pre_rst_rsp1_valid", rsp1_valid, 1);
    checkOutput("pre_rst_rsp1_out", rsp1_out, 8'h0B);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_rsp1_valid", rsp1_valid, 0);
    checkOutput("post_rst_rsp1_out", rsp1_out, 8'h00);
    checkOutput("post_rst_alu_a", alu_a, 8'h00);
    checkOutput("post_rst_alu_b", alu_b, 8'h00);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'h01, 8'h01, 4'b0000);
    applyStimulus(1, 1'b1, 8'h01, 8'h01, 4'b0000);
    #1;
    checkOutput("post_rst_prio_req0", req0_ready, 1);
    checkOutput("post_rst_prio_req1", req1_ready, 0);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 4'b0000);
    applyStimulus(1, 1'b0, 8'h00, 8'h00, 4'b0000);
    rsp1_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("stale%0d_rsp0_valid", c), rsp0_valid, 0);
      checkOutput($sformatf("stale%0d_rsp1_valid", c), rsp1_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
